mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing one single-port synchronous memory (1-cycle read latency) between requester A and requester B.
- Registers the winning command onto the memory port and routes read data back to the issuing requester.
- Holds writes off while the memory reports full; reads are still served while full.
- Sits between the two datapath clients and the memory block.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single-port synchronous memory
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             gnt_a,
  output logic             rvalid_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             gnt_b,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_full,
  output logic             busy
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  owner_t           r_last;
  logic             r_mem_en, r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_t1_v, r_t2_v;
  owner_t           r_t1_own, r_t2_own;
  logic             r_rvalid_a, r_rvalid_b;
  logic [WIDTH-1:0] r_rdata_a, r_rdata_b;

  logic w_elig_a, w_elig_b, w_gnt_a, w_gnt_b;

  // Grants are suppressed while reset is held so nothing is accepted during reset.
  always_comb begin
    w_elig_a = req_a & ~(we_a & mem_full);
    w_elig_b = req_b & ~(we_b & mem_full);
    w_gnt_a  = 1'b0;
    w_gnt_b  = 1'b0;
    if (!rst) begin
      if (w_elig_a && (!w_elig_b || r_last == OWN_B)) w_gnt_a = 1'b1;
      else if (w_elig_b)                              w_gnt_b = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= OWN_B;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_t1_v      <= 1'b0;
      r_t1_own    <= OWN_A;
      r_t2_v      <= 1'b0;
      r_t2_own    <= OWN_A;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
    end else begin
      r_mem_en <= w_gnt_a | w_gnt_b;
      r_mem_we <= (w_gnt_a & we_a) | (w_gnt_b & we_b);
      if (w_gnt_a) begin
        r_mem_addr  <= addr_a;
        r_mem_wdata <= wdata_a;
        r_last      <= OWN_A;
      end else if (w_gnt_b) begin
        r_mem_addr  <= addr_b;
        r_mem_wdata <= wdata_b;
        r_last      <= OWN_B;
      end
      // Tag stage 1 tracks the command on the memory port, stage 2 the cycle its data appears.
      r_t1_v     <= (w_gnt_a & ~we_a) | (w_gnt_b & ~we_b);
      r_t1_own   <= w_gnt_b ? OWN_B : OWN_A;
      r_t2_v     <= r_t1_v;
      r_t2_own   <= r_t1_own;
      r_rvalid_a <= r_t2_v & (r_t2_own == OWN_A);
      r_rvalid_b <= r_t2_v & (r_t2_own == OWN_B);
      if (r_t2_v && r_t2_own == OWN_A) r_rdata_a <= mem_rdata;
      if (r_t2_v && r_t2_own == OWN_B) r_rdata_b <= mem_rdata;
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rvalid_a  = r_rvalid_a;
  assign rvalid_b  = r_rvalid_b;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;
  assign busy      = r_t1_v | r_t2_v;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory and reference model
module tb_mem_arbiter;
  logic        clk, rst;
  logic        req_a, we_a, gnt_a, rvalid_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        req_b, we_b, gnt_b, rvalid_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic        mem_en, mem_we, mem_full, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  mem_arbiter #(.WIDTH(32), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_full(mem_full), .busy(busy)
  );

  typedef struct { bit we; bit [7:0] addr; bit [31:0] wdata; } cmd_t;
  typedef struct { bit owner; bit [31:0] data; int due; } exp_t;

  cmd_t        cmdq_a[$], cmdq_b[$];
  exp_t        expq[$];
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  int          cyc = 0, n_cmp = 0, n_err = 0;
  int          full_mode = 0;
  bit          acc_a = 0, acc_b = 0;
  bit          last_b = 1;
  bit          iss_v = 0, iss_we = 0;
  bit [7:0]    iss_addr = 0;
  bit [31:0]   iss_wdata = 0;
  bit          rd1 = 0, rd2 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Driver: a requester holds its command until accepted, then takes the next one from its queue.
  always @(posedge clk) begin
    cmd_t c;
    #1;
    if (!req_a || acc_a) begin
      if (cmdq_a.size() > 0) begin
        c = cmdq_a.pop_front();
        req_a = 1; we_a = c.we; addr_a = c.addr; wdata_a = c.wdata;
      end else req_a = 0;
    end
    if (!req_b || acc_b) begin
      if (cmdq_b.size() > 0) begin
        c = cmdq_b.pop_front();
        req_b = 1; we_b = c.we; addr_b = c.addr; wdata_b = c.wdata;
      end else req_b = 0;
    end
    case (full_mode)
      0: mem_full = 0;
      1: mem_full = 1;
      2: mem_full = ~mem_full;
      default: mem_full = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: grant decision, memory port contents, busy, and expected read returns.
  always @(negedge clk) begin
    bit ea, eb, ga, gb, rd_now;
    acc_a = 0; acc_b = 0;
    if (rst) begin
      chk("reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_a, gnt_b},
          {1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0});
      last_b = 1; iss_v = 0; rd1 = 0; rd2 = 0;
    end else begin
      chk("mem_en", mem_en, iss_v);
      chk("mem_we", mem_we, iss_v & iss_we);
      if (iss_v) chk("mem_addr_wdata", {mem_addr, mem_wdata}, {iss_addr, iss_wdata});
      chk("busy", busy, rd1 | rd2);
      ea = req_a && !(we_a && mem_full);
      eb = req_b && !(we_b && mem_full);
      ga = ea && (!eb || last_b);
      gb = eb && !ga;
      chk("grant", {gnt_a, gnt_b}, {ga, gb});
      iss_v = ga | gb;
      rd_now = 0;
      if (iss_v) begin
        iss_we    = ga ? we_a : we_b;
        iss_addr  = ga ? addr_a : addr_b;
        iss_wdata = ga ? wdata_a : wdata_b;
        last_b    = gb;
        acc_a = ga; acc_b = gb;
        if (iss_we) ref_mem[iss_addr] = iss_wdata;
        else begin
          expq.push_back('{owner: gb, data: ref_mem[iss_addr], due: cyc + 3});
          rd_now = 1;
        end
      end
      rd2 = rd1; rd1 = rd_now;
    end
  end

  // Monitor: every cycle either the oldest expected read returns now or no rvalid is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("reset_rvalid_rdata", {rvalid_a, rvalid_b, rdata_a, rdata_b}, 66'h0);
      expq.delete();
    end else if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      if (e.owner == 0) begin
        chk("rvalid_a_pulse", {rvalid_a, rvalid_b}, 2'b10);
        chk("rdata_a", rdata_a, e.data);
      end else begin
        chk("rvalid_b_pulse", {rvalid_a, rvalid_b}, 2'b01);
        chk("rdata_b", rdata_b, e.data);
      end
    end else begin
      chk("rvalid_idle", {rvalid_a, rvalid_b}, 2'b00);
    end
  end

  task automatic drain();
    int t = 0;
    while ((cmdq_a.size() > 0 || cmdq_b.size() > 0 || req_a || req_b || expq.size() > 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: still pending after %0d cycles", t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic push(input bit to_b, input bit we, input bit [7:0] addr, input bit [31:0] wd);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wd;
    if (to_b) cmdq_b.push_back(c);
    else      cmdq_a.push_back(c);
  endtask

  initial begin
    int t;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    mem_full = 0; mem_rdata = 0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      tb_mem[i]  = ref_mem[i];
    end
    ref_mem[8'h10] = 32'hDEADBEEF;
    tb_mem[8'h10]  = 32'hDEADBEEF;
    rst = 0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);

    push(0, 0, 8'h10, 0);
    drain();

    for (int i = 0; i < 2; i++) begin
      push(0, 0, 8'(i), 0);
      push(1, 0, 8'(i + 4), 0);
    end
    drain();

    push(1, 1, 8'h20, 32'h55);
    drain();
    push(0, 0, 8'h20, 0);
    drain();

    full_mode = 1;
    push(0, 1, 8'h30, 32'h1234);
    push(1, 0, 8'h30, 0);
    repeat (5) @(negedge clk);
    full_mode = 0;
    drain();

    full_mode = 2;
    for (int i = 0; i < 6; i++) begin
      push(0, 1, 8'(8'h40 + i), $urandom);
      push(1, 0, 8'(8'h40 + i), 0);
    end
    repeat (30) @(negedge clk);
    full_mode = 0;
    drain();

    push(0, 0, 8'h10, 0);
    t = 0;
    while (!acc_a && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_cmp++; n_err++; $display("FAIL accept_timeout: no grant after %0d cycles", t); end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    repeat (4) @(negedge clk);
    push(0, 0, 8'h11, 0);
    push(1, 0, 8'h12, 0);
    drain();

    full_mode = 3;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmdq_a.size() < 2 && $urandom_range(0, 2) != 0)
        push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
      if (cmdq_b.size() < 2 && $urandom_range(0, 2) != 0)
        push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    end
    full_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
